dmem_store_buffer: RTL and testbench
====================================

# dmem_store_buffer

Data-memory responder for the pipelined core's Memory stage. It answers each M-stage load/store issued on `aluoutM`/`writedataM`, returning `readdataM` in the same cycle. Stores go into a small in-order store buffer and drain to a single-ported word array on cycles the port is free. Loads forward from the youngest matching buffered store. The block asserts a stall only when a store meets a full buffer.

## Interface
Parameters:
- `DEPTH`, 4: store-buffer entries; power of two, ≥2.
- `AW`, 6: word-address width; array holds 2^AW 32-bit words.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `memwriteM`  in  1: M-stage store request.
- `memreadM`  in  1: M-stage load request. Never asserted together with `memwriteM`.
- `aluoutM`  in  32: byte address. Bits [AW+1:2] are the word index; all other bits are ignored.
- `writedataM`  in  32: store data.
- `drain_req`  in  1: forces draining, for example before halt or an I/O sync.
- `readdataM`  out  32: load data (combinational).
- `memstallM`  out  1: store not accepted this cycle; the core must hold M and the stages before it.
- `sb_empty`  out  1: buffer holds no pending stores.
- `sb_count`  out  $clog2(DEPTH)+1: number of occupied entries.

## Operation
- State:
  - Entry arrays `addr[DEPTH]` (AW bits) and `data[DEPTH]` (32 bits).
  - `head`/`tail` pointers, $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`.
  - Word array `mem[2^AW]`, which is not reset.
- Load (`memreadM`):
  - `readdataM` = data of the youngest valid entry whose addr matches the word index.
  - Otherwise `readdataM` = `mem[index]`.
  - "Youngest" means the entry closest to `tail`.
- When neither a load nor a store is active, `readdataM` = `mem[index]`. It has no other meaning in that case.
- Store (`memwriteM`):
  - `memstallM` = `memwriteM & (count == DEPTH)`, combinational.
  - If not stalled, the entry at `tail` is written and `tail` advances.
  - Stores are never coalesced; two stores to the same address occupy two entries.
- Drain: `mem[addr[head]] <= data[head]`, `head` advances, `count` decrements. This happens when any of the following is true:
  - the cycle is idle (neither `memreadM` nor `memwriteM`);
  - `memstallM` = 1;
  - `drain_req` = 1 and `memreadM` = 0.
- No drain occurs on a load cycle; loads own the array port.
- Drain with an empty buffer is a no-op.
- Simultaneous drain and accepted store (only possible with `drain_req` = 1 during a store): `count` is unchanged and both pointers advance.
- Full buffer with a store:
  - Cycle 1: stall, and the oldest entry drains.
  - Cycle 2: `memstallM` = 0 and the store is accepted.
- Full buffer with a load: no stall. Forwarding covers all DEPTH entries.
- `sb_empty` = (`count` == 0). `sb_count` = `count`.
- Reset:
  - `head`, `tail`, `count` = 0.
  - `sb_empty` = 1, `memstallM` = 0.
  - Pending stores are discarded. `mem` keeps its contents.

## Timing
- Load latency: 0 cycles. `readdataM` is combinational from `aluoutM`, buffer state and `mem`, and must settle before the W-stage pipeline register captures it.
- Store acceptance and drain writes take effect at the rising edge ending the cycle.
- A load in the cycle right after a store to the same address sees the new data through forwarding.
- `memstallM` depends combinationally on `memwriteM` and registered `count`. No combinational path runs from `memstallM` back into the block.
- Reset assertion mid-drain: the array write for that edge is suppressed, because reset wins asynchronously. Pointers go to 0.
- Occupancy:
  - Worst-case buffer residency is unbounded while loads and stores continue back-to-back.
  - An idle cycle drains exactly one entry.
  - Draining a full buffer takes DEPTH idle or `drain_req` cycles.

## Test plan
- Reset, then load `0x10` → `readdataM` = `mem[4]` preload. Check `sb_empty` = 1, `sb_count` = 0, `memstallM` = 0.
- Store `0xDEADBEEF` to `0x10`, then load `0x10` next cycle → `0xDEADBEEF` (forwarded), `sb_count` = 1. Follow with one idle cycle → `sb_count` = 0 and `mem[4]` = `0xDEADBEEF`.
- Store A=1 to `0x20`, then store B=2 to `0x20`, then load `0x20` → 2 (youngest wins), `sb_count` = 2. Two idle cycles → `mem[8]` = 2.
- Store words 1..4 to `0x0`, `0x4`, `0x8`, `0xC` back-to-back, then a 5th store to `0x30` → `memstallM` = 1 for exactly one cycle and `mem[0]` = 1 after that edge. Next cycle: store accepted, `sb_count` = 4. A load of `0x30` then returns 5's data.
- Fill 3 entries, assert `drain_req` together with a load for 2 cycles → no drain and `sb_count` stays 3. Then `drain_req` alone for 3 cycles → `sb_empty` = 1 and all three words in `mem`.
- Fill 2 entries, drop `reset` low asynchronously mid-cycle → `sb_count` = 0 immediately and `sb_empty` = 1. `mem` locations are unchanged from their pre-store values.

Source files
------------

// File: rtl/dmem_store_buffer_if.sv
// M-stage data-memory bus between the core and the store-buffered data memory.
interface dmem_store_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 6
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          memwriteM;
  logic          memreadM;
  logic [31:0]   aluoutM;
  logic [31:0]   writedataM;
  logic          drain_req;
  logic [31:0]   readdataM;
  logic          memstallM;
  logic          sb_empty;
  logic [CW-1:0] sb_count;

  modport master (
    output memwriteM, memreadM, aluoutM, writedataM, drain_req,
    input  readdataM, memstallM, sb_empty, sb_count
  );

  modport slave (
    input  memwriteM, memreadM, aluoutM, writedataM, drain_req,
    output readdataM, memstallM, sb_empty, sb_count
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Data memory with an in-order store buffer: stores queue up, drain on free port
// cycles, and loads forward from the youngest matching buffered store.
module dmem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 6
) (
  input  logic clk,
  input  logic reset,
  dmem_store_buffer_if.slave bus
);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned WORDS = 1 << AW;

  logic [AW-1:0] entAddr [DEPTH];
  logic [31:0]   entData [DEPTH];
  logic [31:0]   mem     [WORDS];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [AW-1:0] wordIdx;
  logic          full;
  logic          stall;
  logic          storeAcc;
  logic          drainEn;
  logic          fwdHit;
  logic [31:0]   fwdData;
  logic [PW-1:0] fwdIdx;
  logic          unusedAddrBits;

  assign wordIdx        = bus.aluoutM[AW+1:2];
  assign unusedAddrBits = ^{bus.aluoutM[31:AW+2], bus.aluoutM[1:0]};

  assign full     = (count == CW'(DEPTH));
  assign stall    = bus.memwriteM & full;
  assign storeAcc = bus.memwriteM & ~stall;

  // Loads own the array port; any other cycle may retire the oldest entry.
  assign drainEn = (count != '0) &&
                   ((~bus.memreadM & ~bus.memwriteM) | stall |
                    (bus.drain_req & ~bus.memreadM));

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    fwdIdx  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwdIdx = head + PW'(i);
      if ((CW'(i) < count) && (entAddr[fwdIdx] == wordIdx)) begin
        fwdHit  = 1'b1;
        fwdData = entData[fwdIdx];
      end
    end
  end

  assign bus.readdataM = (bus.memreadM && fwdHit) ? fwdData : mem[wordIdx];
  assign bus.memstallM = stall;
  assign bus.sb_empty  = (count == '0);
  assign bus.sb_count  = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (storeAcc) tail <= tail + PW'(1);
      if (drainEn)  head <= head + PW'(1);
      count <= count + CW'(storeAcc) - CW'(drainEn);
    end
  end

  // Entry payloads need no reset; validity is carried by head/count.
  always_ff @(posedge clk) begin
    if (storeAcc) begin
      entAddr[tail] <= wordIdx;
      entData[tail] <= bus.writedataM;
    end
  end

  // count is forced to zero asynchronously, so reset also blocks this write.
  always_ff @(posedge clk) begin
    if (drainEn) mem[entAddr[head]] <= entData[head];
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: a queue/array reference model predicts
// each cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_dmem_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 6;
  localparam int unsigned WORDS = 1 << AW;

  typedef struct {
    logic        isLoad;
    logic [31:0] rd;
    logic        stall;
    int          cnt;
    string       tag;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_store_buffer_if #(.DEPTH(DEPTH), .AW(AW)) bus ();
  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sbQ[$];
  ent_t        mq[$];
  logic [31:0] memModel [WORDS];
  int          checks   = 0;
  int          failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Monitor: one prediction per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      chk({e.tag, " stall"}, 32'(bus.memstallM), 32'(e.stall));
      chk({e.tag, " count"}, 32'(bus.sb_count), 32'(e.cnt));
      chk({e.tag, " empty"}, 32'(bus.sb_empty), 32'(e.cnt == 0));
      if (e.isLoad) chk({e.tag, " rdata"}, bus.readdataM, e.rd);
    end
  end

  // Drive one cycle, predict its outputs, then advance the model across the edge.
  task automatic step(input logic rd, input logic wr, input logic dreq,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic useExp, input logic [31:0] expVal,
                      input string tag, output logic stalled);
    exp_t          e;
    ent_t          n;
    logic [AW-1:0] w;
    logic          drain;
    bus.memreadM   = rd;
    bus.memwriteM  = wr;
    bus.drain_req  = dreq;
    bus.aluoutM    = addr;
    bus.writedataM = wdata;
    w        = addr[AW+1:2];
    e.isLoad = rd;
    e.stall  = wr && (mq.size() == DEPTH);
    e.cnt    = mq.size();
    e.tag    = tag;
    e.rd     = memModel[w];
    foreach (mq[i]) if (mq[i].a == w) e.rd = mq[i].d;
    if (useExp) e.rd = expVal;
    sbQ.push_back(e);
    drain = (!rd && !wr) || e.stall || (dreq && !rd);
    @(posedge clk);
    if (drain && mq.size() > 0) begin
      memModel[mq[0].a] = mq[0].d;
      void'(mq.pop_front());
    end
    if (wr && !e.stall) begin
      n.a = w;
      n.d = wdata;
      mq.push_back(n);
    end
    stalled = e.stall;
    #1;
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [31:0] data, input string tag);
    logic st;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, addr, data, 1'b0, 32'h0, tag, st);
      if (!st) return;
    end
    checks++;
    failures++;
    $display("FAIL %s store_retry actual=stalled required=accepted", tag);
  endtask

  task automatic doLoad(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic st;
    step(1'b1, 1'b0, 1'b0, addr, 32'h0, 1'b1, exp, tag, st);
  endtask

  task automatic doIdle(input int n, input logic dreq, input string tag);
    logic st;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, dreq, 32'h0, 32'h0, 1'b0, 32'h0, tag, st);
  endtask

  initial begin
    logic        st;
    logic [31:0] a;
    int          op;
    reset          = 1'b0;
    bus.memreadM   = 1'b0;
    bus.memwriteM  = 1'b0;
    bus.drain_req  = 1'b0;
    bus.aluoutM    = 32'h0;
    bus.writedataM = 32'h0;
    #12;
    chk("reset count", 32'(bus.sb_count), 32'h0);
    chk("reset empty", 32'(bus.sb_empty), 32'h1);
    chk("reset stall", 32'(bus.memstallM), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < int'(WORDS); i++) doStore(32'(i) << 2, 32'hA500_0000 | 32'(i), "preload");
    doIdle(DEPTH, 1'b0, "preload drain");

    doLoad(32'h10, 32'hA500_0004, "load preload");

    doStore(32'h10, 32'hDEAD_BEEF, "st beef");
    doLoad(32'h10, 32'hDEAD_BEEF, "fwd beef");
    doIdle(1, 1'b0, "drain beef");
    doLoad(32'h10, 32'hDEAD_BEEF, "mem beef");

    doStore(32'h20, 32'h1, "st A");
    doStore(32'h20, 32'h2, "st B");
    doLoad(32'h20, 32'h2, "youngest");
    doIdle(2, 1'b0, "drain AB");
    doLoad(32'h20, 32'h2, "mem AB");

    for (int i = 0; i < 4; i++) doStore(32'(i) << 2, 32'(i + 1), "fill");
    doStore(32'h30, 32'h5, "full store");
    doLoad(32'h30, 32'h5, "fwd full");
    doLoad(32'h0, 32'h1, "drained oldest");
    doIdle(DEPTH, 1'b0, "drain full");

    doStore(32'h50, 32'h111, "f3");
    doStore(32'h54, 32'h222, "f3");
    doStore(32'h58, 32'h333, "f3");
    step(1'b1, 1'b0, 1'b1, 32'h60, 32'h0, 1'b1, 32'hA500_0018, "dreq+load", st);
    step(1'b1, 1'b0, 1'b1, 32'h54, 32'h0, 1'b1, 32'h222, "dreq+load", st);
    doIdle(3, 1'b1, "dreq only");
    doLoad(32'h50, 32'h111, "dreq mem0");
    doLoad(32'h54, 32'h222, "dreq mem1");
    doLoad(32'h58, 32'h333, "dreq mem2");

    doStore(32'h40, 32'h7777_0000, "pre-rst");
    doStore(32'h44, 32'h7777_0001, "pre-rst");
    #2;
    bus.memwriteM = 1'b0;
    reset         = 1'b0;
    #1;
    chk("midrst count", 32'(bus.sb_count), 32'h0);
    chk("midrst empty", 32'(bus.sb_empty), 32'h1);
    chk("midrst stall", 32'(bus.memstallM), 32'h0);
    mq.delete();
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    doLoad(32'h40, 32'hA500_0010, "rst kept0");
    doLoad(32'h44, 32'hA500_0011, "rst kept1");

    for (int i = 0; i < 500; i++) begin
      op = int'($urandom_range(0, 3));
      a  = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      case (op)
        0:       step(1'b0, 1'b0, 1'($urandom_range(0, 1)), a, 32'h0, 1'b0, 32'h0, "rnd idle", st);
        1:       step(1'b1, 1'b0, 1'($urandom_range(0, 1)), a, 32'h0, 1'b0, 32'h0, "rnd load", st);
        default: step(1'b0, 1'b1, ($urandom_range(0, 3) == 0), a, $urandom, 1'b0, 32'h0, "rnd store", st);
      endcase
    end
    doIdle(DEPTH, 1'b0, "final drain");
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'(i) << 2, 32'h0, 1'b0, 32'h0, "final load", st);
    end
    doIdle(1, 1'b0, "tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
